// File: rtl/mont_mul_ctrl_pkg.sv
// Shared definitions for the Montgomery multiplier word-load sequencer:
// operand codes, word geometry, controller states and word-slicing helpers.
package mont_mul_ctrl_pkg;

  localparam int WORD_W   = 32;
  localparam int WORD_CNT = 4;

  localparam logic [1:0] MONT_MUL_OPERAND_A = 2'd0;
  localparam logic [1:0] MONT_MUL_OPERAND_B = 2'd1;
  localparam logic [1:0] MONT_MUL_OPERAND_N = 2'd2;

  localparam logic [1:0] LAST_WORD_IDX = 2'(WORD_CNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  function automatic logic [WORD_W-1:0] word_of(input logic [127:0] v,
                                                 input logic [1:0]   idx);
    return v[idx*WORD_W +: WORD_W];
  endfunction

  // Load sequence position: bits [3:2] pick N/A/B, bits [1:0] are the word offset.
  function automatic logic [1:0] seq_operand(input logic [3:0] seq);
    case (seq[3:2])
      2'd0:    return MONT_MUL_OPERAND_N;
      2'd1:    return MONT_MUL_OPERAND_A;
      default: return MONT_MUL_OPERAND_B;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] seq_word(input logic [3:0]   seq,
                                                 input logic [127:0] a,
                                                 input logic [127:0] b,
                                                 input logic [127:0] n);
    case (seq[3:2])
      2'd0:    return word_of(n, seq[1:0]);
      2'd1:    return word_of(a, seq[1:0]);
      default: return word_of(b, seq[1:0]);
    endcase
  endfunction

endpackage

// File: rtl/mont_mul_ctrl.sv
// Initiator-side sequencer for the Montgomery multiplier: serializes one A/B/N
// command into word writes, starts the multiplier, and streams back the result.
module mont_mul_ctrl
  import mont_mul_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [127:0] cmd_a,
  input  logic [127:0] cmd_b,
  input  logic [127:0] cmd_n,
  input  logic         cmd_skip_n,
  output logic         mm_in_valid,
  output logic [31:0]  mm_in_word,
  output logic [1:0]   mm_in_operand,
  output logic [1:0]   mm_in_offset,
  output logic         mm_start,
  input  logic [127:0] mm_result,
  input  logic         mm_valid,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_word,
  output logic         rsp_last,
  output logic         rsp_error,
  output logic         busy
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      SEQ_N3    = 4'd3;
  localparam logic [3:0]      SEQ_A0    = 4'd4;
  localparam logic [3:0]      SEQ_LAST  = 4'd11;

  state_t        r_state;
  logic [3:0]    r_seq;
  logic [1:0]    r_ridx;
  logic [TW-1:0] r_wait;
  logic [127:0]  r_a;
  logic [127:0]  r_b;
  logic [127:0]  r_n;
  logic [127:0]  r_res;
  logic          r_n_loaded;

  logic          r_cmd_ready;
  logic          r_mm_in_valid;
  logic [31:0]   r_mm_in_word;
  logic [1:0]    r_mm_in_operand;
  logic [1:0]    r_mm_in_offset;
  logic          r_mm_start;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_word;
  logic          r_rsp_last;
  logic          r_rsp_error;
  logic          r_busy;

  logic          w_hs;
  logic          w_skip;
  logic [3:0]    w_seq_first;
  logic [3:0]    w_seq_next;
  logic [1:0]    w_ridx_next;
  logic          w_rsp_fire;

  assign w_hs        = r_cmd_ready & cmd_valid;
  // A skip request is only honoured once some N has actually reached the multiplier.
  assign w_skip      = cmd_skip_n & r_n_loaded;
  assign w_seq_first = w_skip ? SEQ_A0 : 4'd0;
  assign w_seq_next  = r_seq + 4'd1;
  assign w_ridx_next = r_ridx + 2'd1;
  assign w_rsp_fire  = r_rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_seq           <= '0;
      r_ridx          <= '0;
      r_wait          <= '0;
      r_a             <= '0;
      r_b             <= '0;
      r_n             <= '0;
      r_res           <= '0;
      r_n_loaded      <= 1'b0;
      r_cmd_ready     <= 1'b0;
      r_mm_in_valid   <= 1'b0;
      r_mm_in_word    <= '0;
      r_mm_in_operand <= '0;
      r_mm_in_offset  <= '0;
      r_mm_start      <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_word      <= '0;
      r_rsp_last      <= 1'b0;
      r_rsp_error     <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_mm_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_hs) begin
            r_a             <= cmd_a;
            r_b             <= cmd_b;
            r_n             <= cmd_n;
            r_cmd_ready     <= 1'b0;
            r_busy          <= 1'b1;
            r_seq           <= w_seq_first;
            r_mm_in_valid   <= 1'b1;
            r_mm_in_word    <= seq_word(w_seq_first, cmd_a, cmd_b, cmd_n);
            r_mm_in_operand <= seq_operand(w_seq_first);
            r_mm_in_offset  <= w_seq_first[1:0];
            r_state         <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (r_seq == SEQ_N3) begin
            r_n_loaded <= 1'b1;
          end
          if (r_seq == SEQ_LAST) begin
            r_mm_in_valid   <= 1'b0;
            r_mm_in_word    <= '0;
            r_mm_in_operand <= '0;
            r_mm_in_offset  <= '0;
            r_mm_start      <= 1'b1;
            r_state         <= ST_START;
          end else begin
            r_seq           <= w_seq_next;
            r_mm_in_word    <= seq_word(w_seq_next, r_a, r_b, r_n);
            r_mm_in_operand <= seq_operand(w_seq_next);
            r_mm_in_offset  <= w_seq_next[1:0];
          end
        end

        ST_START: begin
          r_wait  <= '0;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A done strobe on the final wait cycle still counts as success.
          if (mm_valid) begin
            r_res       <= mm_result;
            r_ridx      <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_word  <= word_of(mm_result, 2'd0);
            r_rsp_last  <= 1'b0;
            r_rsp_error <= 1'b0;
            r_state     <= ST_DRAIN;
          end else if (r_wait == WAIT_LAST) begin
            r_rsp_valid <= 1'b1;
            r_rsp_word  <= '0;
            r_rsp_last  <= 1'b1;
            r_rsp_error <= 1'b1;
            r_state     <= ST_DRAIN;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (w_rsp_fire) begin
            if (r_rsp_last) begin
              r_rsp_valid <= 1'b0;
              r_rsp_word  <= '0;
              r_rsp_last  <= 1'b0;
              r_rsp_error <= 1'b0;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_ridx     <= w_ridx_next;
              r_rsp_word <= word_of(r_res, w_ridx_next);
              r_rsp_last <= (w_ridx_next == LAST_WORD_IDX);
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign mm_in_valid   = r_mm_in_valid;
  assign mm_in_word    = r_mm_in_word;
  assign mm_in_operand = r_mm_in_operand;
  assign mm_in_offset  = r_mm_in_offset;
  assign mm_start      = r_mm_start;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_word      = r_rsp_word;
  assign rsp_last      = r_rsp_last;
  assign rsp_error     = r_rsp_error;
  assign busy          = r_busy;

endmodule

// File: tb/tb_mont_mul_ctrl.sv
// Scoreboard bench for mont_mul_ctrl: stimulus pushes expected writes, start
// cycles and responses; a negedge monitor pops and compares them.
module tb_mont_mul_ctrl;

  localparam int TMO = 160;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [127:0] cmd_a = '0;
  logic [127:0] cmd_b = '0;
  logic [127:0] cmd_n = '0;
  logic         cmd_skip_n = 1'b0;
  logic         mm_in_valid;
  logic [31:0]  mm_in_word;
  logic [1:0]   mm_in_operand;
  logic [1:0]   mm_in_offset;
  logic         mm_start;
  logic [127:0] mm_result = '0;
  logic         mm_valid = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [31:0]  rsp_word;
  logic         rsp_last;
  logic         rsp_error;
  logic         busy;

  mont_mul_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_n(cmd_n), .cmd_skip_n(cmd_skip_n),
    .mm_in_valid(mm_in_valid), .mm_in_word(mm_in_word),
    .mm_in_operand(mm_in_operand), .mm_in_offset(mm_in_offset),
    .mm_start(mm_start), .mm_result(mm_result), .mm_valid(mm_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word),
    .rsp_last(rsp_last), .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  always @(negedge clk) ncyc <= ncyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  off;
    logic [31:0] w;
  } wr_t;

  wr_t         wr_q[$];
  int          start_q[$];
  logic [33:0] rsp_q[$];   // {last, error, word}

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, ncyc);
  endtask

  // Monitor / scoreboard
  initial begin
    wr_t         e;
    logic [33:0] r;
    int          s;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_rsp = '0;
    logic        prev_start = 1'b0;
    logic        idle_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (idle_pending) begin
        chk("idle_after_drain", {cmd_ready, busy}, 2'b10);
        idle_pending = 1'b0;
      end
      if (mm_in_valid) begin
        if (wr_q.size() == 0) fail("wr_extra");
        else begin
          e = wr_q.pop_front();
          chk("wr", {mm_in_operand, mm_in_offset, mm_in_word}, {e.op, e.off, e.w});
        end
      end
      if (mm_start) begin
        chk("start_single", prev_start, 1'b0);
        if (start_q.size() == 0) fail("start_extra");
        else begin
          s = start_q.pop_front();
          chk("start_cycle", ncyc, s);
        end
      end
      prev_start = mm_start;
      if (prev_stall)
        chk("stall_stable", {rsp_valid, rsp_last, rsp_error, rsp_word}, {1'b1, prev_rsp});
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) fail("rsp_extra");
        else begin
          r = rsp_q.pop_front();
          chk("rsp", {rsp_last, rsp_error, rsp_word}, r);
        end
        if (rsp_last) idle_pending = 1'b1;
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_rsp   = {rsp_last, rsp_error, rsp_word};
    end
  end

  task automatic push_load(input logic [127:0] a, b, n, input logic full);
    if (full) for (int i = 0; i < 4; i++) wr_q.push_back('{2'd2, 2'(i), n[32*i +: 32]});
    for (int i = 0; i < 4; i++) wr_q.push_back('{2'd0, 2'(i), a[32*i +: 32]});
    for (int i = 0; i < 4; i++) wr_q.push_back('{2'd1, 2'(i), b[32*i +: 32]});
  endtask

  task automatic push_rsp(input logic [127:0] res);
    for (int i = 0; i < 4; i++) rsp_q.push_back({(i == 3), 1'b0, res[32*i +: 32]});
  endtask

  task automatic wait_neg(input int t);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ncyc != t && k < 5000);
    if (ncyc != t) fail("wait_neg_timeout");
  endtask

  // m = negedge index seen just before the handshake edge; cycle c is observed at m+c.
  task automatic send(input logic [127:0] a, b, n, input logic skip, input logic full,
                      output int m);
    int k = 0;
    push_load(a, b, n, full);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_n = n; cmd_skip_n = skip;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 200);
    if (!cmd_ready) fail("cmd_ready_timeout");
    m = ncyc;
    start_q.push_back(m + (full ? 13 : 9));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("busy_during_op", {busy, cmd_ready}, 2'b10);
  endtask

  task automatic pulse_mm(input int t, input logic [127:0] res);
    wait_neg(t - 1);
    @(posedge clk);
    #1;
    mm_valid = 1'b1; mm_result = res;
    @(posedge clk);
    #1;
    mm_valid = 1'b0; mm_result = '0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(cmd_ready && !busy) && k < 3000);
    if (!(cmd_ready && !busy)) fail("idle_timeout");
    chk("wr_q_empty", wr_q.size(), 0);
    chk("start_q_empty", start_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
  endtask

  task automatic check_zero(input string name);
    chk(name, {cmd_ready, mm_in_valid, mm_in_word, mm_in_operand, mm_in_offset, mm_start,
               rsp_valid, rsp_word, rsp_last, rsp_error, busy}, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int m;
    logic [127:0] r2;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_initial");
    rst_n = 1'b1;

    // Full load then result 1,2,3,4
    send(128'h1, 128'h2, 128'hD, 1'b0, 1'b1, m);
    push_rsp(128'h00000004_00000003_00000002_00000001);
    pulse_mm(m + 150, 128'h00000004_00000003_00000002_00000001);
    wait_idle();

    // Skip N (already loaded), stall response word 2 for five cycles
    r2 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    send(128'h11112222_33334444_55556666_77778888, 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000,
         128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 1'b1, 1'b0, m);
    push_rsp(r2);
    pulse_mm(m + 40, r2);
    @(negedge clk);
    chk("rsp_word0_seen", {rsp_valid, rsp_word}, {1'b1, 32'hAAAA0001});
    @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("stall_word2", {rsp_valid, rsp_last, rsp_word}, {1'b1, 1'b0, 32'hCCCC0003});
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle();

    // Skip requested right after reset: N still loaded; then timeout
    do_reset();
    send(128'h0A, 128'h0B, 128'h0C0000000000000000000000000000F1, 1'b1, 1'b1, m);
    rsp_q.push_back({1'b1, 1'b1, 32'h0});
    wait_neg(m + 14 + TMO - 1);
    chk("no_rsp_before_timeout", rsp_valid, 1'b0);
    @(negedge clk);
    chk("timeout_rsp_present", {rsp_valid, rsp_error, rsp_last}, 3'b111);
    wait_idle();

    // mm_valid on the timeout cycle wins
    send(128'h5, 128'h6, 128'h7, 1'b1, 1'b0, m);
    push_rsp(128'h00000040_00000030_00000020_00000010);
    pulse_mm(m + 10 + TMO - 1, 128'h00000040_00000030_00000020_00000010);
    wait_idle();

    // Reset during LOAD at word 5, then skip must reload N
    send(128'h3, 128'h4, 128'h0000000F_0000000E, 1'b0, 1'b1, m);
    wait_neg(m + 5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_load");
    wr_q.delete();
    start_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(128'h21, 128'h22, 128'h23, 1'b1, 1'b1, m);
    push_rsp(128'h44444444_33333333_22222222_11111111);
    pulse_mm(m + 30, 128'h44444444_33333333_22222222_11111111);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
